// File: rtl/mul_share_pkg.sv
// Shared types and helpers for the round-robin multiplier scheduler.
// Optional perf counters in the top are enabled with MUL_SHARE_PERF_CNT_EN.
package mul_share_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_WIDTH = 16;
  localparam int MAX_REQ   = 8;
  localparam int PTR_W     = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One-hot grant: first valid requester at or after ptr, wrapping at n.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input logic [PTR_W-1:0]   ptr,
                                                 input int                 n);
    logic [MAX_REQ-1:0] grant;
    int idx;
    grant = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = (int'(ptr) + i) % n;
      if (i < n && grant == '0 && valid[idx]) grant[idx] = 1'b1;
    end
    return grant;
  endfunction

endpackage

// File: rtl/mul_serial_core.sv
// Serial shift-add multiplier datapath: one multiplier bit consumed per step.
module mul_serial_core #(
  parameter int WIDTH = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplr;

  // acc_o already includes the current multiplier bit, so the final step's
  // result can be captured on the same edge that performs it.
  assign acc_o = acc + (mplr[0] ? mcand : '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc   <= '0;
      mcand <= '0;
      mplr  <= '0;
    end else if (load_i) begin
      acc   <= '0;
      mcand <= {{WIDTH{1'b0}}, a_i};
      mplr  <= b_i;
    end else if (step_i) begin
      acc   <= acc_o;
      mcand <= mcand << 1;
      mplr  <= mplr >> 1;
    end
  end

endmodule

// File: rtl/mul_share_sched.sv
// Round-robin scheduler sharing one serial multiplier among N_REQ requesters.
// Define MUL_SHARE_PERF_CNT_EN to add perf_busy_o / perf_jobs_o counters.
module mul_share_sched
  import mul_share_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_REQ-1:0]       req_valid_i,
  output logic [N_REQ-1:0]       req_ready_o,
  input  logic [N_REQ*WIDTH-1:0] req_a_i,
  input  logic [N_REQ*WIDTH-1:0] req_b_i,
  output logic                   resp_valid_o,
  input  logic                   resp_ready_i,
  output logic [ID_W-1:0]        resp_id_o,
  output logic [2*WIDTH-1:0]     resp_prod_o,
`ifdef MUL_SHARE_PERF_CNT_EN
  output logic [31:0]            perf_busy_o,
  output logic [31:0]            perf_jobs_o,
`endif
  output logic                   resp_ovf_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t             state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    cur_id;
  logic [CNT_W-1:0]   cnt;
  logic [MAX_REQ-1:0] valid_pad;
  logic [MAX_REQ-1:0] grant_pad;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W-1:0]    next_ptr;
  logic               accept;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic [2*WIDTH-1:0] acc;

  always_comb begin
    valid_pad = '0;
    valid_pad[N_REQ-1:0] = req_valid_i;
    grant_pad = rr_pick(valid_pad, PTR_W'(rr_ptr), N_REQ);
    grant_id  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_pad[k]) grant_id = ID_W'(k);
    end
  end

  // Grant is withheld during reset so no job can slip in on a reset edge.
  assign req_ready_o = (state == IDLE && !rst_i) ? grant_pad[N_REQ-1:0] : '0;
  assign accept      = |req_ready_o;
  assign next_ptr    = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
  assign sel_a       = req_a_i[grant_id*WIDTH +: WIDTH];
  assign sel_b       = req_b_i[grant_id*WIDTH +: WIDTH];

  mul_serial_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (accept),
    .step_i (state == RUN),
    .a_i    (sel_a),
    .b_i    (sel_b),
    .acc_o  (acc)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      cur_id       <= '0;
      cnt          <= '0;
      resp_valid_o <= 1'b0;
      resp_id_o    <= '0;
      resp_prod_o  <= '0;
      resp_ovf_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cur_id <= grant_id;
            rr_ptr <= next_ptr;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state        <= DONE;
            resp_valid_o <= 1'b1;
            resp_prod_o  <= acc;
            resp_id_o    <= cur_id;
            resp_ovf_o   <= |acc[2*WIDTH-1:WIDTH];
          end
        end
        DONE: begin
          if (resp_ready_i) begin
            state        <= IDLE;
            resp_valid_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MUL_SHARE_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_busy_o <= '0;
      perf_jobs_o <= '0;
    end else begin
      if (state != IDLE) perf_busy_o <= perf_busy_o + 32'd1;
      if (accept)        perf_jobs_o <= perf_jobs_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mul_share_sched.sv
// Directed self-checking bench for mul_share_sched (4 requesters, 16-bit operands).
module tb_mul_share_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [1:0]  resp_id;
  logic [31:0] resp_prod;
  logic        resp_ovf;
`ifdef MUL_SHARE_PERF_CNT_EN
  logic [31:0] perf_busy;
  logic [31:0] perf_jobs;
`endif

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int prev_resp_cycle = 0;

  mul_share_sched dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_id_o    (resp_id),
    .resp_prod_o  (resp_prod),
`ifdef MUL_SHARE_PERF_CNT_EN
    .perf_busy_o  (perf_busy),
    .perf_jobs_o  (perf_jobs),
`endif
    .resp_ovf_o   (resp_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic ready);
    req_valid  = valid;
    resp_ready = ready;
  endtask

  task automatic setOperands(input int k, input logic [15:0] a, input logic [15:0] b);
    req_a[k*16 +: 16] = a;
    req_b[k*16 +: 16] = b;
  endtask

  // Waits for a grant, lets it be accepted, then times the response.
  task automatic serveOne(input string tag, input logic [3:0] exp_grant, input logic drop,
                          input logic [1:0] exp_id, input logic [31:0] exp_prod,
                          input logic exp_ovf, input logic chk_gap);
    int n;
    logic [3:0] g;
    #1;
    n = 0;
    while (req_ready == 4'b0 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    g = req_ready;
    checkOutput({tag, "_grant"}, 64'(g), 64'(exp_grant));
    if (g != 4'b0) begin
      @(negedge clk);
      if (drop) req_valid = req_valid & ~g;
      n = 0;
      while (!resp_valid && n < 60) begin
        @(negedge clk);
        n++;
      end
      checkOutput({tag, "_latency"}, 64'(n), 64'd16);
      checkOutput({tag, "_id"}, 64'(resp_id), 64'(exp_id));
      checkOutput({tag, "_prod"}, 64'(resp_prod), 64'(exp_prod));
      checkOutput({tag, "_ovf"}, 64'(resp_ovf), 64'(exp_ovf));
      if (chk_gap) checkOutput({tag, "_gap"}, 64'(cycle - prev_resp_cycle), 64'd18);
      prev_resp_cycle = cycle;
    end
  endtask

  initial begin
    int seen;
    rst   = 1'b1;
    req_a = '0;
    req_b = '0;
    applyStimulus(4'b1111, 1'b0);
    @(negedge clk);
    checkOutput("reset_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    checkOutput("reset_valid", 64'(resp_valid), 64'd0);
    checkOutput("reset_prod", 64'(resp_prod), 64'd0);
    checkOutput("reset_id", 64'(resp_id), 64'd0);
    checkOutput("reset_ovf", 64'(resp_ovf), 64'd0);
    rst = 1'b0;
    applyStimulus(4'b0000, 1'b1);
    @(negedge clk);

    // Single request 3*5 from requester 0
    setOperands(0, 16'd3, 16'd5);
    applyStimulus(4'b0001, 1'b1);
    serveOne("single", 4'b0001, 1'b1, 2'd0, 32'd15, 1'b0, 1'b0);
    @(negedge clk);

    // Max operands from requester 1, then hold the response under backpressure
    setOperands(1, 16'hFFFF, 16'hFFFF);
    applyStimulus(4'b0010, 1'b0);
    serveOne("max", 4'b0010, 1'b1, 2'd1, 32'hFFFE0001, 1'b1, 1'b0);
    setOperands(3, 16'h0000, 16'h1234);
    applyStimulus(4'b1000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("bp_valid", 64'(resp_valid), 64'd1);
      checkOutput("bp_prod", 64'(resp_prod), 64'hFFFE0001);
      checkOutput("bp_id", 64'(resp_id), 64'd1);
      checkOutput("bp_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("bp_release_valid", 64'(resp_valid), 64'd0);
    checkOutput("bp_release_grant", 64'(req_ready), 64'b1000);

    // Zero operand on requester 3; pointer wraps back to requester 0
    serveOne("zero", 4'b1000, 1'b1, 2'd3, 32'd0, 1'b0, 1'b0);

    // Fairness: all four valid continuously
    setOperands(0, 16'd2, 16'd10);
    setOperands(1, 16'd3, 16'd11);
    setOperands(2, 16'd4, 16'd12);
    setOperands(3, 16'd5, 16'd13);
    applyStimulus(4'b1111, 1'b1);
    serveOne("fair0", 4'b0001, 1'b0, 2'd0, 32'd20, 1'b0, 1'b1);
    serveOne("fair1", 4'b0010, 1'b0, 2'd1, 32'd33, 1'b0, 1'b1);
    serveOne("fair2", 4'b0100, 1'b0, 2'd2, 32'd48, 1'b0, 1'b1);
    serveOne("fair3", 4'b1000, 1'b0, 2'd3, 32'd65, 1'b0, 1'b1);
    serveOne("fair4", 4'b0001, 1'b0, 2'd0, 32'd20, 1'b0, 1'b1);

    // Reset while requester 2's job is at cnt=7
    setOperands(2, 16'd100, 16'd200);
    applyStimulus(4'b0100, 1'b1);
    @(negedge clk);
    #1;
    checkOutput("mid_grant", 64'(req_ready), 64'b0100);
    @(negedge clk);
    req_valid = 4'b0000;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid_rst_valid", 64'(resp_valid), 64'd0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    checkOutput("mid_rst_no_resp", 64'(seen), 64'd0);
    // Pointer back at 0 means requester 2 wins over requester 3
    applyStimulus(4'b1100, 1'b1);
    serveOne("post_rst", 4'b0100, 1'b1, 2'd2, 32'd20000, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b1);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_share_sched.md
Name: mul_share_sched

Overview:
- Round-robin scheduler sharing one serial shift-add multiplier among N_REQ requesters.
- Per-requester valid/ready request handshake; single valid/ready response channel tagged with the requester id.
- Sits between client blocks and the serial multiplier datapath. Replaces per-client multipliers.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 16, operand width; the product is 2*WIDTH.
- ID_W, $clog2(N_REQ), width of the requester id.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- req_valid_i  in  N_REQ  per-requester request valid.
- req_ready_o  out  N_REQ  per-requester accept; at most one bit high.
- req_a_i  in  N_REQ*WIDTH  multiplicand; requester k uses bits [k*WIDTH +: WIDTH].
- req_b_i  in  N_REQ*WIDTH  multiplier; same packing as req_a_i.
- resp_valid_o  out  1  product available.
- resp_ready_i  in  1  consumer accepts the product.
- resp_id_o  out  ID_W  index of the requester that owns the product.
- resp_prod_o  out  2*WIDTH  unsigned product a*b.
- resp_ovf_o  out  1  high when resp_prod_o[2*WIDTH-1:WIDTH] != 0.

Behaviour:
- Clocking and reset: one clock, clk_i. rst_i is synchronous, active-high.
- Reset values:
  - State = IDLE; rr_ptr = 0.
  - resp_valid_o = 0, resp_id_o = 0, resp_prod_o = 0, resp_ovf_o = 0.
  - req_ready_o = 0 during the reset cycle.
- Reset mid-operation: the in-flight product is discarded and no response is produced.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - The grant scans requesters rr_ptr, rr_ptr+1, ... mod N_REQ. The first one with req_valid_i set gets req_ready_o[k] = 1.
  - req_ready_o is combinational from state, rr_ptr and req_valid_i.
- Acceptance edge (req_valid_i[k] & req_ready_o[k]):
  - Capture operands into the datapath: accumulator = 0, multiplicand = a_k zero-extended to 2*WIDTH, multiplier shift register = b_k.
  - Latch id = k; rr_ptr <= (k+1) mod N_REQ; cnt <= 0; state <= RUN.
- RUN, one bit per cycle:
  - If the multiplier LSB = 1, accumulator += multiplicand.
  - Multiplicand shifts left by 1; multiplier shifts right by 1; cnt++.
  - After the WIDTH-th RUN edge (cnt == WIDTH-1), state <= DONE.
  - The response registers load accumulator, id and the overflow bit on that edge.
- Latency: resp_valid_o rises exactly WIDTH cycles after the acceptance edge (16 for the default).
- DONE:
  - resp_valid_o = 1; resp_* held stable until resp_ready_i.
  - On the resp_valid_o & resp_ready_i edge: state <= IDLE, resp_valid_o <= 0.
  - The next acceptance can occur on the following edge, so there is one bubble cycle between jobs.
- Throughput: one product per WIDTH+2 cycles maximum.
- req_ready_o is 0 in RUN and DONE, so requests arriving then wait. Requesters must hold valid and operands until accepted.
- Ignored inputs:
  - resp_ready_i outside DONE has no effect.
  - A requester that drops req_valid_i while not granted loses nothing.
- Arithmetic: unsigned. Product is exact in 2*WIDTH bits; no truncation.
- Boundary values:
  - a=0 or b=0 gives product 0.
  - a=b=2^WIDTH-1 gives the full-width product with resp_ovf_o = 1.
- rr_ptr wraps from N_REQ-1 to 0.

Optional Feature:
- Macro: MUL_SHARE_PERF_CNT_EN.
- When defined, two extra outputs are added:
  - perf_busy_o (32-bit): increments every cycle state != IDLE.
  - perf_jobs_o (32-bit): increments on each acceptance edge.
  - Both clear on rst_i and wrap on overflow.
- When undefined, neither port nor its registers exist; all other behaviour is identical.

Decomposition:
- Package mul_share_pkg holds:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - default WIDTH/N_REQ constants;
  - function rr_pick(valid, ptr) returning the one-hot grant.
- Sub-module mul_serial_core holds the shift-add datapath: load, step and accumulator out.
- mul_share_sched owns the FSM, counter, arbiter and response registers.

Test Plan:
- Single request: req 0 with a=3, b=5, resp_ready_i=1 -> resp_valid_o rises 16 cycles after acceptance; resp_prod_o=15, resp_id_o=0, resp_ovf_o=0.
- Max operands: a=b=16'hFFFF -> resp_prod_o=32'hFFFE0001, resp_ovf_o=1.
- Fairness: all 4 requesters valid continuously with resp_ready_i=1 -> grant order 0,1,2,3,0; each response arrives 18 cycles after the previous one, with ids matching the grant order.
- Backpressure: resp_ready_i=0 for 10 cycles in DONE -> outputs stable, req_ready_o all 0; resp_ready_i=1 -> IDLE next cycle, next grant on the following edge.
- Reset mid-RUN: assert rst_i at cnt=7 -> next cycle resp_valid_o=0, rr_ptr=0, no response emitted; a fresh request from req 2 is then served correctly (a=100, b=200 -> 20000).
- Zero and wrap: req 3 with a=0, b=16'h1234 -> product 0, id 3, and rr_ptr wraps so requester 0 is prioritised next.
